// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (I-cache / D-cache) arbiter in front of a single shared
//            line-wide memory port. Grants are registered; each transaction
//            ends with one dead DONE cycle before the next arbitration.
// Options  : MEM_ARB_RR_EN - when defined, simultaneous requests are resolved
//            round-robin with a 1-bit pointer; otherwise the D-cache always
//            wins.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache port
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  // D-cache port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  // Shared memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // Status
  output logic              busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GNT_I = 2'd1;
  localparam logic [1:0] c_GNT_D = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_pick_d;
  logic              w_i_done;
  logic              w_d_done;

  assign w_req_i  = i_read;
  assign w_req_d  = d_read | d_write;
  // mem_ready only counts while a grant is actually outstanding
  assign w_i_done = (r_state == c_GNT_I) && mem_ready;
  assign w_d_done = (r_state == c_GNT_D) && mem_ready;

`ifdef MEM_ARB_RR_EN
  // r_ptr_d=1 means the D-cache wins the next tie; flips after every completion
  logic r_ptr_d;

  // Round-robin pointer: hand priority to the side that was not just served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr_d <= 1'b1;
    end else if (w_d_done) begin
      r_ptr_d <= 1'b0;
    end else if (w_i_done) begin
      r_ptr_d <= 1'b1;
    end
  end

  assign w_pick_d = w_req_d && (!w_req_i || r_ptr_d);
`else
  assign w_pick_d = w_req_d;
`endif

  // Arbitration FSM and registered memory request fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pick_d) begin
            // A read+write collision is served as a write-back
            r_state     <= c_GNT_D;
            r_mem_write <= d_write;
            r_mem_read  <= ~d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_write ? d_wdata : '0;
          end else if (w_req_i) begin
            r_state     <= c_GNT_I;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
          end
        end
        c_GNT_I, c_GNT_D: begin
          // Request fields stay frozen until memory answers, even if the
          // requester lets go early
          if (mem_ready) begin
            r_state     <= c_DONE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        c_DONE: begin
          // Dead cycle so the finished requester can drop its request
          r_state <= c_IDLE;
        end
        default: begin
          r_state     <= c_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign i_ready = w_i_done;
  assign d_ready = w_d_done;
  assign i_rdata = w_i_done ? mem_rdata : '0;
  // Write grants return no data to the D-cache
  assign d_rdata = (w_d_done && r_mem_read) ? mem_rdata : '0;
  assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire
